// File: rtl/common.sv
// Shared fetch/decode types: the instruction word type, the NOP encoding that
// fills an empty IF/ID slot, and the {pc, instr} entry held by the fetch buffer.
package common;

  typedef logic [31:0] instruction_type;

  // addi x0, x0, 0
  localparam instruction_type NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0]     pc;
    instruction_type instr;
  } fetch_entry_type;

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO of fetch entries. The head is visible combinationally
// so the IF/ID register downstream acts as the registered read stage.
// Flush has priority over push and pop.
module fetch_buffer
  import common::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_entry_type        push_entry,
  output fetch_entry_type        head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  fetch_entry_type entries [DEPTH];
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [AW:0]     count_reg;
  logic            do_push;
  logic            do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == DEPTH_C);
  assign do_pop  = pop && !empty;
  // A full buffer may still take a push when the head leaves on the same edge.
  assign do_push = push && (!full || do_pop);
  assign head    = entries[rd_ptr_reg];
  assign count   = count_reg;

  // Pointer and occupancy tracking; flush empties the buffer outright.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Entry storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push && !flush) entries[wr_ptr_reg] <= push_entry;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues in-order word requests, buffers
// returned words with their PCs and drives the IF/ID register into decode.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN adds a sticky fetch_misaligned
// flag raised by a misaligned redirect, which also halts issue until reset.
module fetch_stage
  import common::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [31:0]     imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  input  logic            redirect_valid,
  input  logic [31:0]     redirect_pc,
  input  logic            hazard,
  output instruction_type instruction,
  output logic [31:0]     pc,
  output logic            if_valid
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic            fetch_misaligned
`endif
);

  localparam int CNT_W  = $clog2(BUF_DEPTH) + 1;
  // Drops can pile up across back-to-back redirects against a slow memory.
  localparam int DROP_W = CNT_W + 4;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(BUF_DEPTH);

  logic [31:0]       fetch_pc_reg;
  logic [31:0]       resp_pc_reg;     // PC of the oldest live outstanding request
  logic [CNT_W-1:0]  outstanding_reg;
  logic [DROP_W-1:0] drop_reg;
  instruction_type   instr_reg;
  logic [31:0]       pc_reg;
  logic              if_valid_reg;

  logic [31:0]       target_pc;
  logic              issue_block;
  logic              req_fire;
  logic              resp_take;
  logic              resp_drop;
  logic [CNT_W:0]    slots_used;

  fetch_entry_type   buf_head;
  fetch_entry_type   buf_in;
  logic [CNT_W-1:0]  buf_count;
  logic              buf_empty;
  logic              buf_full;
  logic              buf_push;
  logic              buf_pop;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misaligned_reg;

  assign target_pc        = redirect_pc;
  assign issue_block      = misaligned_reg;
  assign fetch_misaligned = misaligned_reg;

  // Sticky trap flag set by any redirect to a non-word-aligned target.
  always_ff @(posedge clk) begin
    if (reset) begin
      misaligned_reg <= 1'b0;
    end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
      misaligned_reg <= 1'b1;
    end
  end
`else
  assign target_pc   = redirect_pc & ~32'h0000_0003;
  assign issue_block = 1'b0;
`endif

  // The entry leaving the buffer this edge frees its slot in time for a new
  // request, which keeps one fetch per cycle with a 1-cycle memory.
  assign buf_pop    = !hazard && !redirect_valid && !buf_empty;
  assign slots_used = (CNT_W+1)'(outstanding_reg) + (CNT_W+1)'(buf_count)
                    - (CNT_W+1)'(buf_pop);

  assign imem_req_valid = !reset && !redirect_valid && !issue_block
                        && (slots_used < DEPTH_C);
  assign imem_req_addr  = fetch_pc_reg;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Responses consume pending drops first; only the rest are real fetches.
  assign resp_drop = imem_resp_valid && (drop_reg != '0);
  assign resp_take = imem_resp_valid && (drop_reg == '0);
  assign buf_push  = resp_take && !redirect_valid && (!buf_full || buf_pop);

  assign buf_in.pc    = resp_pc_reg;
  assign buf_in.instr = imem_resp_data;

  fetch_buffer #(
    .DEPTH (BUF_DEPTH)
  ) u_buffer (
    .clk        (clk),
    .reset      (reset),
    .push       (buf_push),
    .pop        (buf_pop),
    .flush      (redirect_valid),
    .push_entry (buf_in),
    .head       (buf_head),
    .count      (buf_count),
    .empty      (buf_empty),
    .full       (buf_full)
  );

  // Program counter and request/response bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_reg    <= RESET_PC;
      resp_pc_reg     <= RESET_PC;
      outstanding_reg <= '0;
      drop_reg        <= '0;
    end else if (redirect_valid) begin
      fetch_pc_reg    <= target_pc;
      resp_pc_reg     <= target_pc;
      outstanding_reg <= '0;
      // Every still-live request becomes a drop; a response arriving now is
      // itself discarded, either using up a drop or retiring one outstanding.
      drop_reg        <= drop_reg + DROP_W'(outstanding_reg) - DROP_W'(imem_resp_valid);
    end else begin
      if (req_fire) fetch_pc_reg <= fetch_pc_reg + 32'd4;
      if (buf_push) resp_pc_reg  <= resp_pc_reg + 32'd4;
      outstanding_reg <= outstanding_reg + CNT_W'(req_fire) - CNT_W'(resp_take);
      drop_reg        <= drop_reg - DROP_W'(resp_drop);
    end
  end

  // IF/ID register: redirect flushes, hazard holds, otherwise load head or NOP.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_reg    <= NOP_INSTR;
      pc_reg       <= RESET_PC;
      if_valid_reg <= 1'b0;
    end else if (redirect_valid) begin
      instr_reg    <= NOP_INSTR;
      if_valid_reg <= 1'b0;
    end else if (!hazard) begin
      if (!buf_empty) begin
        instr_reg    <= buf_head.instr;
        pc_reg       <= buf_head.pc;
        if_valid_reg <= 1'b1;
      end else begin
        instr_reg    <= NOP_INSTR;
        if_valid_reg <= 1'b0;
      end
    end
  end

  assign instruction = instr_reg;
  assign pc          = pc_reg;
  assign if_valid    = if_valid_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a behavioural memory answers requests in
// order with random latency; a reference model predicts the IF/ID stream
// (sequential PCs from the last reset/redirect target) and issue eligibility.
module tb_fetch_stage;
  import common::*;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam int          DEPTH  = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            imem_req_valid;
  logic            imem_req_ready = 1'b0;
  logic [31:0]     imem_req_addr;
  logic            imem_resp_valid = 1'b0;
  logic [31:0]     imem_resp_data = 32'h0;
  logic            redirect_valid = 1'b0;
  logic [31:0]     redirect_pc = 32'h0;
  logic            hazard = 1'b0;
  instruction_type instruction;
  logic [31:0]     pc;
  logic            if_valid;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic            fetch_misaligned;
`endif

  always #5 clk = ~clk;

  fetch_stage #(
    .RESET_PC  (RST_PC),
    .BUF_DEPTH (DEPTH)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .hazard          (hazard),
    .instruction     (instruction),
    .pc              (pc),
    .if_valid        (if_valid)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .fetch_misaligned (fetch_misaligned)
`endif
  );

  typedef struct { logic [31:0] addr; int epoch; int due; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;

  mreq_t memq[$];   // requests accepted by memory, in order
  exp_t  pend[$];   // live fetches whose words have not returned
  exp_t  avail[$];  // words returned and waiting for IF/ID

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int epoch    = 0;
  int hs_count = 0;
  int n_ret    = 0;
  int lat_min  = 1;
  int lat_max  = 1;

  logic [31:0] model_pc  = RST_PC;
  logic        exp_valid = 1'b0;
  logic [31:0] exp_pc    = RST_PC;
  logic [31:0] exp_instr = NOP_INSTR;
  logic        trap      = 1'b0;
  logic        req_v_s   = 1'b0;
  logic [31:0] req_a_s   = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0003;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Memory: present the oldest accepted request once its latency has elapsed.
  always @(negedge clk) begin
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(memq[0].addr);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'h0;
    end
  end

  // Snapshot the request outputs once this cycle's inputs have settled.
  always @(negedge clk) begin
    #2;
    req_v_s = imem_req_valid;
    req_a_s = imem_req_addr;
  end

  // Reference model and monitor.
  always @(posedge clk) begin
    logic  pop;
    logic  exp_rv;
    int    used;
    exp_t  e;
    mreq_t m;
    cyc++;
    if (reset) begin
      chk("req_valid_in_reset", 32'(req_v_s), 32'd0);
      memq.delete(); pend.delete(); avail.delete();
      epoch++;
      model_pc  = RST_PC;
      trap      = 1'b0;
      hs_count  = 0;
      exp_valid = 1'b0;
      exp_pc    = RST_PC;
      exp_instr = NOP_INSTR;
    end else begin
      pop    = !hazard && !redirect_valid && (avail.size() > 0);
      used   = pend.size() + avail.size() - (pop ? 1 : 0);
      exp_rv = !redirect_valid && !trap && (used < DEPTH);
      chk("req_valid", 32'(req_v_s), 32'(exp_rv));
      if (redirect_valid) begin
        exp_valid = 1'b0;
        exp_instr = NOP_INSTR;
      end else if (!hazard) begin
        if (avail.size() > 0) begin
          e = avail.pop_front();
          exp_valid = 1'b1;
          exp_pc    = e.pc;
          exp_instr = e.instr;
          n_ret++;
          $display("retire pc=%h instr=%h cycle %0d", e.pc, e.instr, cyc);
        end else begin
          exp_valid = 1'b0;
          exp_instr = NOP_INSTR;
        end
      end
      if (imem_resp_valid && memq.size() > 0) begin
        m = memq.pop_front();
        if (m.epoch == epoch && !redirect_valid && pend.size() > 0)
          avail.push_back(pend.pop_front());
      end
      if (req_v_s && imem_req_ready) begin
        chk("req_addr", req_a_s, model_pc);
        hs_count++;
        e.pc    = model_pc;
        e.instr = mem_word(model_pc);
        pend.push_back(e);
        m.addr  = req_a_s;
        m.epoch = epoch;
        m.due   = cyc + $urandom_range(lat_max, lat_min) - 1;
        memq.push_back(m);
        model_pc = model_pc + 32'd4;
      end
      if (redirect_valid) begin
        epoch++;
        pend.delete();
        avail.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
        model_pc = redirect_pc;
        if (redirect_pc[1:0] != 2'b00) trap = 1'b1;
`else
        model_pc = redirect_pc & ~32'h0000_0003;
`endif
      end
    end
    #1;
    chk("if_valid", 32'(if_valid), 32'(exp_valid));
    chk("instruction", instruction, exp_instr);
    if (exp_valid || reset) chk("pc", pc, exp_pc);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("fetch_misaligned", 32'(fetch_misaligned), 32'(trap));
`endif
  end

  // Stimulus.
  initial begin
    int hs_before;
    logic [31:0] rpc;
    repeat (3) @(negedge clk);

    // Clean start: 1-cycle memory, no hazard -> back-to-back requests.
    imem_req_ready = 1'b1;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("first_three_requests", 32'(hs_count), 32'd3);
    repeat (8) @(negedge clk);

    // Hazard held for 3 cycles mid-stream.
    hazard = 1'b1;
    repeat (3) @(negedge clk);
    hazard = 1'b0;
    repeat (6) @(negedge clk);

    // Redirect with a slow memory so requests are still outstanding.
    lat_min = 3; lat_max = 3;
    repeat (6) @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    @(negedge clk);
    redirect_valid = 1'b0;
    repeat (10) @(negedge clk);
    lat_min = 1; lat_max = 1;
    repeat (4) @(negedge clk);

    // Redirect and hazard in the same cycle.
    hazard = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0300;
    @(negedge clk);
    redirect_valid = 1'b0;
    @(negedge clk);
    hazard = 1'b0;
    repeat (8) @(negedge clk);

    // Memory not ready for 4 cycles.
    imem_req_ready = 1'b0;
    repeat (4) @(negedge clk);
    imem_req_ready = 1'b1;
    repeat (6) @(negedge clk);

    // Randomized traffic.
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 2500; i++) begin
      imem_req_ready = ($urandom_range(0, 99) < 75);
      hazard         = ($urandom_range(0, 99) < 20);
      redirect_valid = ($urandom_range(0, 99) < 3);
      rpc = $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
      rpc[1:0] = 2'b00;
`endif
      redirect_pc = rpc;
      reset = ($urandom_range(0, 999) < 3);
      @(negedge clk);
    end
    reset = 1'b0; redirect_valid = 1'b0; hazard = 1'b0; imem_req_ready = 1'b1;
    lat_min = 1; lat_max = 1;
    repeat (10) @(negedge clk);

    // Misaligned redirect target.
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0202;
    @(negedge clk);
    redirect_valid = 1'b0;
    hs_before = hs_count;
    repeat (8) @(negedge clk);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("trap_sticky", 32'(fetch_misaligned), 32'd1);
    chk("trap_no_issue", 32'(hs_count - hs_before), 32'd0);
`else
    chk("aligned_resume", 32'(hs_count - hs_before), 32'd8);
`endif

    chk("retired_enough", 32'(n_ret > 500), 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
